// File: rtl/fifo_unpacker_pkg.sv
// Shared constants and helpers for the FIFO unpacker.
// Provides a constant-evaluable ceil(log2) used to size the beat counter.
package fifo_unpacker_pkg;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = 1;
    while (v < value) begin
      v   = v << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Wide-to-narrow unpacker fed by a show-ahead FIFO.
// Pops one IN_WIDTH word, then emits it as IN_WIDTH/OUT_WIDTH beats, LSB slice first,
// over a valid/ready handshake. o_last flags the final beat of each word.
// Ports:
//   clk          - clock, all state on rising edge
//   i_rst        - synchronous active-high reset
//   i_fifo_data  - FIFO head word (valid while !i_fifo_empty)
//   i_fifo_empty - FIFO empty flag
//   o_fifo_ren   - FIFO pop strobe (combinational)
//   i_flush      - drop the held word and its remaining beats
//   o_valid      - beat valid (registered)
//   o_data       - beat data (registered)
//   o_last       - beat is the last slice of its word
//   i_ready      - consumer accepts the beat when o_valid && i_ready
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 512,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [IN_WIDTH-1:0]  i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_ren,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : gen_width_check
    $error("fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic                hold_vld_q, hold_vld_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic accept;
  logic is_last;
  logic pop;

  assign accept  = hold_vld_q && i_ready;
  assign is_last = (beat_cnt_q == LastCnt);
  // Refill when idle, or in the same cycle the last beat leaves, so words stream back-to-back.
  assign pop     = !i_rst && !i_flush && !i_fifo_empty && (!hold_vld_q || (accept && is_last));

  assign o_fifo_ren = pop;
  assign o_valid    = hold_vld_q;
  assign o_data     = shreg_q[OUT_WIDTH-1:0];
  assign o_last     = is_last;

  always_comb begin
    hold_vld_d = hold_vld_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    if (i_flush) begin
      // Flush wins over pop and accept; the shift register contents become don't-care.
      hold_vld_d = 1'b0;
      beat_cnt_d = '0;
    end else if (pop) begin
      shreg_d    = i_fifo_data;
      beat_cnt_d = '0;
      hold_vld_d = 1'b1;
    end else if (accept) begin
      if (is_last) begin
        hold_vld_d = 1'b0;
      end else begin
        shreg_d    = shreg_q >> OUT_WIDTH;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      hold_vld_q <= 1'b0;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
